// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline sequencing logic
package pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and pipeline control outputs of the sequencing controller
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_pkg::*;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             idex_md_i;
  logic             branch_taken_i;
  logic             imem_stall_i;
  logic             dmem_stall_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             pipe_freeze_o;
  logic             md_start_o;
  logic             md_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, idex_md_i,
           branch_taken_i, imem_stall_i, dmem_stall_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           pipe_freeze_o, md_start_o, md_busy_o, stall_cnt_o
  );
  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, idex_md_i,
           branch_taken_i, imem_stall_i, dmem_stall_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           pipe_freeze_o, md_start_o, md_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter with synchronous active-low clear, holds at all-ones
module sat_counter #(parameter int W = 32) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !rst_i ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/freeze sequencing with fixed-latency MUL/DIV tracking
module hazard_ctrl import pipe_pkg::*; #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  hazard_ctrl_if.slave hz
);
  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use, md_start, freeze;
  logic [3:0] ctl;
  assign load_use = hz.idex_memread_i && hz.idex_rt_i != REG_ZERO &&
                    (hz.idex_rt_i == hz.ifid_rs_i || hz.idex_rt_i == hz.ifid_rt_i);
  assign md_start = rst_i && state_q == IDLE && hz.idex_md_i && !hz.dmem_stall_i;
  assign freeze   = rst_i && (hz.dmem_stall_i || state_q == MD_BUSY || md_start);
  // {pc_write, ifid_write, ifid_flush, idex_flush}, highest priority first
  always_comb
    ctl = !rst_i             ? 4'b0011 :
          freeze             ? 4'b0000 :
          load_use           ? 4'b0001 :
          hz.branch_taken_i  ? 4'b1110 :
          hz.imem_stall_i    ? 4'b0110 : 4'b1100;
  assign {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_flush_o} = ctl;
  assign hz.pipe_freeze_o = freeze;
  assign hz.md_start_o    = md_start;
  assign hz.md_busy_o     = md_start || (rst_i && state_q == MD_BUSY);
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // MD_DONE never restarts, so the finishing instruction cannot retrigger itself
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (md_start) begin
        state_d = MD_BUSY;
        cnt_d   = 4'(MD_LATENCY - 1);
      end
      MD_BUSY: if (cnt_q == 4'd1) state_d = MD_DONE;
               else cnt_d = cnt_q - 4'd1;
      MD_DONE: state_d = hz.dmem_stall_i ? MD_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!hz.pc_write_o),
    .cnt_o (hz.stall_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; each row drives one cycle and queues the expected controls
module tb_hazard_ctrl;
  localparam logic [6:0] RST   = 7'b0011000;
  localparam logic [6:0] DEF   = 7'b1100000;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1110000;
  localparam logic [6:0] IM    = 7'b0110000;
  localparam logic [6:0] START = 7'b0000111;
  localparam logic [6:0] BUSY  = 7'b0000101;
  localparam logic [6:0] DFRZ  = 7'b0000100;
  localparam logic [6:0] ALL   = 7'b1111111;
  localparam logic [6:0] NOIW  = 7'b1011111;
  typedef struct packed {
    logic       rst, mr;
    logic [4:0] rt, rs, rtt;
    logic       md, br, im, dm;
    logic [6:0] ctl, mask;
    logic [3:0] cnt;
  } row_t;
  typedef struct packed {
    logic [6:0] ctl, mask;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  row_t stim_q[$];
  exp_t sb[$];
  logic [6:0] obs;
  hazard_ctrl_if #(.CNT_W(4)) ifc ();
  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (.clk_i(clk), .rst_i(rst), .hz(ifc.slave));
  always #5 clk = ~clk;
  assign obs = {ifc.pc_write_o, ifc.ifid_write_o, ifc.ifid_flush_o, ifc.idex_flush_o,
                ifc.pipe_freeze_o, ifc.md_start_o, ifc.md_busy_o};
  task automatic add(input logic r, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                     input logic [4:0] rtt, input logic md, input logic br, input logic im,
                     input logic dm, input logic [6:0] ctl, input logic [6:0] mask,
                     input logic [3:0] cnt);
    stim_q.push_back({r, mr, rt, rs, rtt, md, br, im, dm, ctl, mask, cnt});
  endtask
  task automatic apply(input row_t r);
    rst                = r.rst;
    ifc.idex_memread_i = r.mr;
    ifc.idex_rt_i      = r.rt;
    ifc.ifid_rs_i      = r.rs;
    ifc.ifid_rt_i      = r.rtt;
    ifc.idex_md_i      = r.md;
    ifc.branch_taken_i = r.br;
    ifc.imem_stall_i   = r.im;
    ifc.dmem_stall_i   = r.dm;
    sb.push_back({r.ctl, r.mask, r.cnt});
  endtask
  task automatic do_reset;
    apply('0);
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_reset;
    row_t r; exp_t e; int n = 0;
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, ALL, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, RST, ALL, 0);
    add(0, 1, 3, 3, 3, 1, 1, 1, 1, RST, ALL, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL reset row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_load_use;
    row_t r; exp_t e; int n = 0;
    do_reset;
    add(1, 1, 8, 8, 0, 0, 0, 0, 0, LU,  ALL, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 1);
    add(1, 1, 9, 3, 9, 0, 0, 0, 0, LU,  ALL, 1);
    add(1, 1, 9, 3, 4, 0, 0, 0, 0, DEF, ALL, 2);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL load_use row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_muldiv;
    row_t r; exp_t e; int n = 0;
    do_reset;
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, START, ALL, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, BUSY,  ALL, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, BUSY,  ALL, 2);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, BUSY,  ALL, 3);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, DEF,   ALL, 4);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   ALL, 4);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL muldiv row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_md_dmem;
    row_t r; exp_t e; int n = 0;
    do_reset;
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, DFRZ,  ALL, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, START, ALL, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, BUSY,  ALL, 2);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, BUSY,  ALL, 3);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, BUSY,  ALL, 4);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, DFRZ,  ALL, 5);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, DFRZ,  ALL, 6);
    add(1, 0, 0, 0, 0, 1, 0, 0, 1, DFRZ,  ALL, 7);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, DEF,   ALL, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   ALL, 8);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL md_dmem row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_priority;
    row_t r; exp_t e; int n = 0;
    do_reset;
    add(1, 1, 5, 5, 0, 0, 1, 0, 0, LU,   ALL,  0);
    add(1, 0, 0, 0, 0, 0, 1, 1, 0, BR,   NOIW, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, IM,   ALL,  1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  ALL,  2);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, BR,   NOIW, 2);
    add(1, 1, 5, 5, 0, 0, 1, 1, 1, DFRZ, ALL,  2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  ALL,  3);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL priority row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_reset_mid_md;
    row_t r; exp_t e; int n = 0;
    do_reset;
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, START, ALL, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, BUSY,  ALL, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, RST,   ALL, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   ALL, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF,   ALL, 0);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL reset_mid_md row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  task automatic test_saturation;
    row_t r; exp_t e; int n = 0;
    do_reset;
    for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, IM, ALL, 4'(i > 15 ? 15 : i));
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 15);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, ALL, 15);
    while (stim_q.size() > 0) begin
      r = stim_q.pop_front(); apply(r); #2;
      e = sb.pop_front(); total++;
      if ((obs & e.mask) !== (e.ctl & e.mask) || ifc.stall_cnt_o !== e.cnt) begin
        bad++;
        $display("FAIL saturation row=%0d ctl=%b exp=%b cnt=%0d exp=%0d", n, obs, e.ctl, ifc.stall_cnt_o, e.cnt);
      end
      n++; @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    apply('0);
    void'(sb.pop_front());
    @(negedge clk);
    test_reset;
    test_load_use;
    test_muldiv;
    test_md_dmem;
    test_priority;
    test_reset_mid_md;
    test_saturation;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding logic.
- Drives PC-write, IF/ID-write/flush, ID/EX bubble insertion and a whole-pipeline freeze.
- Covers load-use hazards, taken-branch flushes, instruction-memory misses, data-memory wait states, and a fixed-latency multi-cycle MUL/DIV unit in EX.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MD_LATENCY, 4: frozen cycles for a MUL/DIV in EX; legal range 2..15.
- CNT_W, 32: width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset: synchronous, active-low.
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination register of that load.
- ifid_rs_i  in  5  rs of the instruction in IF/ID.
- ifid_rt_i  in  5  rt of the instruction in IF/ID.
- idex_md_i  in  1  instruction in ID/EX is MUL/DIV.
- branch_taken_i  in  1  branch resolved taken in ID.
- imem_stall_i  in  1  instruction fetch not ready.
- dmem_stall_i  in  1  data memory not ready.
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID register enable.
- ifid_flush_o  out  1  load NOP into IF/ID.
- idex_flush_o  out  1  load bubble (control zero) into ID/EX.
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- md_start_o  out  1  one-cycle start pulse to the MUL/DIV unit.
- md_busy_o  out  1  MUL/DIV operation in progress.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o low, saturating.

Behaviour:
- State register: IDLE, MD_BUSY, MD_DONE. MD count register is 4 bits.
- While rst_i is low at a clock edge: state becomes IDLE, count becomes 0, stall_cnt_o becomes 0.
- Outputs during reset: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_flush_o=1, pipe_freeze_o=0, md_start_o=0, md_busy_o=0.
- Reset asserted mid-MUL/DIV discards the operation; there is no resume.
- All outputs other than stall_cnt_o are combinational from state and inputs. Priority is highest first:
  1. Freeze.
     - freeze = dmem_stall_i OR state==MD_BUSY OR md_start_o.
     - Outputs: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_flush_o=0, pipe_freeze_o=1.
  2. Load-use.
     - Condition: idex_memread_i AND idex_rt_i!=0 AND (idex_rt_i==ifid_rs_i OR idex_rt_i==ifid_rt_i).
     - Outputs: pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
     - A concurrent branch_taken_i is ignored; the branch re-resolves next cycle.
  3. Branch taken.
     - Outputs: pc_write_o=1, ifid_flush_o=1.
     - Overrides imem_stall_i: the redirect abandons the pending miss.
  4. Instruction miss (imem_stall_i).
     - Outputs: pc_write_o=0, ifid_write_o=1, ifid_flush_o=1; a bubble enters ID.
  5. Default: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- md_start_o = (state==IDLE) AND idex_md_i AND NOT dmem_stall_i.
  - Not generated in MD_DONE, so the same instruction cannot retrigger.
- FSM transitions:
  - IDLE: if md_start_o, load count=MD_LATENCY-1 and go to MD_BUSY.
  - MD_BUSY: if count==1 go to MD_DONE, else decrement count. The count runs regardless of dmem_stall_i.
  - MD_DONE: stay while dmem_stall_i; otherwise go to IDLE. The unfrozen MD_DONE cycle is the writeback/advance cycle.
- Latency: start pulse at cycle T. Frozen cycles are T..T+MD_LATENCY-1, i.e. MD_LATENCY cycles. First unfrozen cycle is T+MD_LATENCY.
- md_busy_o = md_start_o OR state==MD_BUSY.
- stall_cnt_o increments by 1 on each edge where pc_write_o==0 and rst_i high. It holds at all-ones and does not wrap.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (IDLE, MD_BUSY, MD_DONE);
  - register-zero constant;
  - REG_W=5.
- One natural sub-module: sat_counter (parameterised width, enable, sync active-low clear, saturate at max). Used for stall_cnt_o.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles, then release with all inputs 0 -> during reset ifid_flush_o=1, idex_flush_o=1, pc_write_o=0; first cycle after release pc_write_o=1, stall_cnt_o=0.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for one cycle -> pc_write_o=0, ifid_write_o=0, idex_flush_o=1, stall_cnt_o +1. Repeat with idex_rt_i=0 -> no stall.
- MUL/DIV: MD_LATENCY=4, idex_md_i=1 held -> md_start_o pulses once at T; pipe_freeze_o=1 for T..T+3; T+4 unfrozen with no new start pulse; stall_cnt_o +4.
- dmem stall during MD: dmem_stall_i=1 from T+2 to T+6 -> freeze continuous T..T+6; FSM reaches MD_DONE at T+4 and stays; unfrozen at T+7 with no retrigger.
- Branch vs load-use vs imem miss:
  - branch_taken_i=1 with load-use true -> stall only, no flush.
  - branch_taken_i=1 with imem_stall_i=1 -> pc_write_o=1, ifid_flush_o=1.
  - imem_stall_i=1 alone -> pc_write_o=0, ifid_flush_o=1.
- Saturation: CNT_W=4, imem_stall_i=1 for 20 cycles -> stall_cnt_o reaches 15 and holds.
